// File: rtl/alu_flags_stage.sv
// alu_flags_stage: registered NZCV flag stage behind the CLA add/sub datapath.
// Holds one output entry plus a single skid entry so in_ready can be a pure
// register. Also tracks a sticky overflow flag and a saturating overflow count.
module alu_flags_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_c,
  input  logic             in_of,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v,
  output logic             out_sub,
  input  logic             clr_sticky,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_cnt
);

  // Entry layout: {sub, v, c, z, n, res}
  localparam int EW    = WIDTH + 5;
  localparam int N_B   = WIDTH;
  localparam int Z_B   = WIDTH + 1;
  localparam int C_B   = WIDTH + 2;
  localparam int V_B   = WIDTH + 3;
  localparam int SUB_B = WIDTH + 4;

  logic [EW-1:0]    out_ent_q, out_ent_d;
  logic [EW-1:0]    skid_ent_q, skid_ent_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          ovf_ev;
  logic [EW-1:0] in_ent;

  // Ready depends only on skid occupancy, so there is no comb path from out_ready.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign ovf_ev   = accept & in_of;

  // Flags are derived once at capture and travel with the entry.
  assign in_ent = {in_sub, in_of, in_c, (in_sum == '0), in_sum[WIDTH-1], in_sum};

  // Output/skid next state: skid always drains ahead of new input to keep FIFO order.
  always_comb begin
    out_ent_d    = out_ent_q;
    out_valid_d  = out_valid_q;
    skid_ent_d   = skid_ent_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_ent_d    = skid_ent_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_ent_d = in_ent;
      end
      out_valid_d = skid_valid_q | accept;
      // Skid moved out while a new entry arrives: new entry refills the skid.
      if (skid_valid_q && accept) begin
        skid_ent_d   = in_ent;
        skid_valid_d = 1'b1;
      end
    end else if (accept) begin
      skid_ent_d   = in_ent;
      skid_valid_d = 1'b1;
    end
  end

  // Sticky overflow and saturating count; a same-cycle overflow wins over clear.
  always_comb begin
    sticky_d = sticky_q | ovf_ev;
    cnt_d    = cnt_q;
    if (clr_sticky) begin
      sticky_d = ovf_ev;
      cnt_d    = ovf_ev ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (ovf_ev && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset; reset discards both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ent_q    <= '0;
      skid_ent_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_ent_q    <= out_ent_d;
      skid_ent_q   <= skid_ent_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_ent_q[WIDTH-1:0];
  assign out_n     = out_ent_q[N_B];
  assign out_z     = out_ent_q[Z_B];
  assign out_c     = out_ent_q[C_B];
  assign out_v     = out_ent_q[V_B];
  assign out_sub   = out_ent_q[SUB_B];
  assign sticky_v  = sticky_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_flags_stage.sv
// Bench for alu_flags_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. A second instance with a
// 2-bit counter exercises saturation alongside the default 8-bit instance.
module tb_alu_flags_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_c, in_of, in_sub, out_ready, clr_sticky;
  logic [31:0] in_sum;

  logic        in_ready, out_valid, out_n, out_z, out_c, out_v, out_sub, sticky_v;
  logic [31:0] out_res;
  logic [7:0]  ovf_cnt;

  logic        in_ready2, out_valid2, out_n2, out_z2, out_c2, out_v2, out_sub2, sticky_v2;
  logic [31:0] out_res2;
  logic [1:0]  ovf_cnt2;

  alu_flags_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_c(in_c), .in_of(in_of), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v),
    .out_sub(out_sub), .clr_sticky(clr_sticky), .sticky_v(sticky_v), .ovf_cnt(ovf_cnt)
  );

  alu_flags_stage #(.WIDTH(32), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_sum(in_sum),
    .in_c(in_c), .in_of(in_of), .in_sub(in_sub), .out_valid(out_valid2), .out_ready(out_ready),
    .out_res(out_res2), .out_n(out_n2), .out_z(out_z2), .out_c(out_c2), .out_v(out_v2),
    .out_sub(out_sub2), .clr_sticky(clr_sticky), .sticky_v(sticky_v2), .ovf_cnt(ovf_cnt2)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic        n, z, c, v, sub;
  } ent_t;

  ent_t mq[$];
  bit   m_live = 0;
  bit   m_zero = 0;
  bit   m_sticky = 0;
  int   m_cnt8 = 0;
  int   m_cnt2 = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
      m_live = 1; m_zero = 1;
    end else if (m_live) begin
      bit acc;
      bit ovf;
      int sz;
      sz  = mq.size();
      acc = in_valid && (sz < 2);
      if (sz > 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{in_sum, in_sum[31], (in_sum == 32'h0), in_c, in_of, in_sub});
        m_zero = 0;
      end
      ovf = acc && in_of;
      if (clr_sticky) begin
        m_sticky = ovf; m_cnt8 = ovf ? 1 : 0; m_cnt2 = ovf ? 1 : 0;
      end else if (ovf) begin
        m_sticky = 1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(negedge clk);
    if (m_live) begin
      chk("m.out_valid", out_valid, mq.size() > 0);
      chk("m.in_ready", in_ready, mq.size() < 2);
      chk("m.in_ready2", in_ready2, mq.size() < 2);
      chk("m.sticky_v", sticky_v, m_sticky);
      chk("m.sticky_v2", sticky_v2, m_sticky);
      chk("m.ovf_cnt", ovf_cnt, m_cnt8);
      chk("m.ovf_cnt2", ovf_cnt2, m_cnt2);
      if (mq.size() > 0) begin
        chk("m.out_res", out_res, mq[0].res);
        chk("m.out_res2", out_res2, mq[0].res);
        chk("m.nzcv", {out_n, out_z, out_c, out_v}, {mq[0].n, mq[0].z, mq[0].c, mq[0].v});
        chk("m.out_sub", out_sub, mq[0].sub);
      end else if (m_zero) begin
        chk("m.rst_data", {out_res, out_n, out_z, out_c, out_v, out_sub}, 37'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [31:0] s, input logic c, input logic of, input logic sb);
    in_valid = v; in_sum = s; in_c = c; in_of = of; in_sub = sb;
  endtask

  task automatic scen1(input string tag);
    out_ready = 1'b1;
    drv(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tick();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".res"}, out_res, 32'h8000_0000);
    chk({tag, ".nzcv"}, {out_n, out_z, out_c, out_v}, 4'b1001);
    chk({tag, ".sticky"}, sticky_v, 1);
    chk({tag, ".cnt"}, ovf_cnt, 1);
    tick();
    chk({tag, ".drained"}, out_valid, 0);
  endtask

  int exp2[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1; out_ready = 1'b0; clr_sticky = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk("rst.valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.res", out_res, 0);
    chk("rst.sticky", sticky_v, 0);
    chk("rst.cnt", ovf_cnt, 0);

    // Scenario 1: negative overflowing add
    scen1("s1");

    // Scenario 2: 5-5 subtract
    drv(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    tick();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("s2.res", out_res, 0);
    chk("s2.nzcv", {out_n, out_z, out_c, out_v}, 4'b0110);
    chk("s2.sub", out_sub, 1);
    tick();

    // Scenario 3: back-pressure with A,B,C, then release
    out_ready = 1'b0;
    drv(1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b0); tick();
    chk("s3.a_out", out_res, 32'h1111_0001);
    chk("s3.rdy_a", in_ready, 1);
    drv(1'b1, 32'h2222_0002, 1'b1, 1'b0, 1'b0); tick();
    chk("s3.rdy_b", in_ready, 0);
    chk("s3.a_hold", out_res, 32'h1111_0001);
    drv(1'b1, 32'h3333_0003, 1'b0, 1'b0, 1'b1); tick();
    chk("s3.c_held", in_ready, 0);
    chk("s3.a_stable", out_res, 32'h1111_0001);
    out_ready = 1'b1; tick();
    chk("s3.b_out", out_res, 32'h2222_0002);
    chk("s3.rdy_back", in_ready, 1);
    tick();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("s3.c_out", out_res, 32'h3333_0003);
    chk("s3.c_valid", out_valid, 1);
    tick();
    chk("s3.empty", out_valid, 0);

    // Scenario 4: full stage, drain while input pending
    out_ready = 1'b0;
    drv(1'b1, 32'h0000_00A0, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b1, 32'h0000_00B0, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b1, 32'h0000_00D0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1; tick();
    chk("s4.skid_out", out_res, 32'h0000_00B0);
    chk("s4.rdy", in_ready, 1);
    out_ready = 1'b0; tick();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("s4.refill", in_ready, 0);
    chk("s4.b_hold", out_res, 32'h0000_00B0);
    out_ready = 1'b1; tick();
    chk("s4.d_out", out_res, 32'h0000_00D0);
    tick();

    // Scenario 5: counter saturation and clear/set collision
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    chk("s5.clr_cnt", ovf_cnt2, 0);
    chk("s5.clr_sticky", sticky_v, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 32'h7FFF_FFF0 + i, 1'b0, 1'b1, 1'b0);
      tick();
      chk($sformatf("s5.cnt2_%0d", i), ovf_cnt2, exp2[i]);
      chk($sformatf("s5.cnt8_%0d", i), ovf_cnt, i + 1);
    end
    clr_sticky = 1'b1;
    drv(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0); tick();
    chk("s5.clrset_cnt2", ovf_cnt2, 1);
    chk("s5.clrset_cnt8", ovf_cnt, 1);
    chk("s5.clrset_sticky", sticky_v, 1);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    clr_sticky = 1'b0;
    chk("s5.clr_only", {sticky_v, ovf_cnt}, 9'h0);

    // Scenario 6: reset with both entries valid
    out_ready = 1'b0;
    drv(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1); tick();
    drv(1'b1, 32'hCAFE_0000, 1'b1, 1'b1, 1'b0); tick();
    chk("s6.full", in_ready, 0);
    rst = 1'b1; drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    chk("s6.valid", out_valid, 0);
    chk("s6.in_ready", in_ready, 1);
    chk("s6.data", {out_res, out_n, out_z, out_c, out_v, out_sub}, 37'h0);
    chk("s6.sticky_cnt", {sticky_v, ovf_cnt}, 9'h0);
    scen1("s6.post");

    // Mixed traffic under random back-pressure; model does the checking
    for (int i = 0; i < 300; i++) begin
      logic [31:0] s;
      s = $urandom();
      if ($urandom_range(0, 3) == 0) s = 32'h0;
      drv($urandom_range(0, 1) == 1, s, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      out_ready  = $urandom_range(0, 2) != 0;
      clr_sticky = $urandom_range(0, 40) == 0;
      tick();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    clr_sticky = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
